video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Raster timing source driving the pixel generator: produces pixel_cnt, line_cnt, video_on, h_sync and v_sync.
//  Sits between the pixel-clock PLL (rfr_clk) and pixel_gen/VGA DAC; all outputs registered and mutually cycle-aligned.
//  Small run/drain FSM: display starts and stops only on frame boundaries, so pixel_gen's v_sync edge fires once per frame.
// PARAMETERS
//  H_ACTIVE 640 visible pixels/line; H_FP 16 front porch; H_SYNC 96 sync width; H_BP 48 back porch (H_TOTAL=800)
//  V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33 (V_TOTAL=525)
//  HS_POL 1'b0 asserted level of h_sync; VS_POL 1'b0 asserted level of v_sync
//  FRAME_W 16 width of frame_cnt
// PORTS
//  rfr_clk      in   1   pixel clock; one clock, all logic on posedge
//  reset        in   1   synchronous, active-high reset
//  en           in   1   request raster output; sampled every cycle
//  pixel_cnt    out  12  horizontal position, 0..H_TOTAL-1
//  line_cnt     out  12  vertical position, 0..V_TOTAL-1
//  video_on     out  1   1 iff pixel_cnt<H_ACTIVE && line_cnt<V_ACTIVE && state!=IDLE
//  h_sync       out  1   HS_POL iff H_ACTIVE+H_FP <= pixel_cnt < H_ACTIVE+H_FP+H_SYNC (not IDLE)
//  v_sync       out  1   VS_POL iff V_ACTIVE+V_FP <= line_cnt < V_ACTIVE+V_FP+V_SYNC (not IDLE)
//  frame_start  out  1   1-cycle pulse while output position is (0,0)
//  line_end     out  1   1-cycle pulse while pixel_cnt==H_TOTAL-1
//  running      out  1   1 when state is RUN or DRAIN
//  frame_cnt    out  FRAME_W  completed frames, wraps 2^FRAME_W-1 -> 0
// BEHAVIOUR
//  Reset (sync, dominates en): state=IDLE; pixel_cnt=0, line_cnt=0, video_on=0, h_sync=~HS_POL, v_sync=~VS_POL,
//   frame_start=0, line_end=0, running=0, frame_cnt=0. Reset mid-frame aborts immediately; no drain.
//  All outputs come from registers; decode computed from next-state counters so every output describes
//   the same (pixel_cnt,line_cnt) in the same cycle. No combinational path from en to outputs.
//  FSM:
//   IDLE : counters held 0, outputs inactive. en=1 -> RUN; first RUN cycle shows (0,0), video_on=1, frame_start=1.
//   RUN  : pixel_cnt increments each cycle; at H_TOTAL-1 wraps to 0 and line_cnt increments;
//          line_cnt wraps V_TOTAL-1 -> 0. en=0 -> DRAIN (no positional effect).
//   DRAIN: counts as RUN. en=1 -> RUN, raster uninterrupted. At (H_TOTAL-1,V_TOTAL-1) with en=0 -> IDLE:
//          next cycle counters 0, syncs inactive, video_on=0, frame_start=0.
//   Last pixel of frame in RUN with en=1: wraps to (0,0), frame_start=1.
//  frame_cnt increments on the cycle leaving (H_TOTAL-1,V_TOTAL-1), including the transition to IDLE.
//  Counters 12-bit unsigned; H_TOTAL, V_TOTAL <= 4096 (elaboration-time assertion). Compare against
//   precomputed localparam boundaries; no subtraction.
//  Sync pulses are glitch-free and exactly H_SYNC cycles / V_SYNC lines wide. v_sync changes only when pixel_cnt==0.
// STRUCTURE
//  video_timing_pkg: timing_state_e {IDLE,RUN,DRAIN}; default 640x480@60 timing constants; derived
//   H_TOTAL/V_TOTAL/sync start/end localparams; shared with pixel_gen (MAX_PIXEL=H_ACTIVE, MAX_LINE=V_ACTIVE).
//  One sub-module, timing_counter (WIDTH, TERMINAL): clear/inc inputs, count and tc outputs.
//   Instantiated twice: horizontal (inc always in RUN/DRAIN), vertical (inc = horizontal tc).
//  Top: FSM, sync/video_on/pulse registers, frame_cnt.
// TESTING
//  1 Reset=1 for 3 cycles with en=1 -> all outputs at reset values; h_sync=v_sync=1 (HS_POL=VS_POL=0).
//  2 Release reset, en=1 -> next cycle (0,0), video_on=1, frame_start=1; then video_on=0 first at pixel 640.
//    h_sync=0 for pixel 656..751 exactly (96 cycles); line_cnt=1 when pixel_cnt returns to 0.
//  3 Full frame -> v_sync=0 on lines 490..491 only; 420000 cycles between frame_start pulses; frame_cnt 0->1.
//  4 en=0 at (100,200) -> running stays 1 through (799,524); IDLE next cycle; frame_cnt increments once.
//    Separately, en low 50 cycles then high mid-frame -> no break in counting.
//  5 Reset asserted at (300,250) -> next cycle all outputs at reset values.
//    With en=1 after release, restarts at (0,0) with frame_start=1.
//  6 Force frame_cnt to 16'hFFFF, complete frame -> frame_cnt=0.
//    Randomized run: assert video_on/h_sync/v_sync equal decode of pixel_cnt,line_cnt every cycle.

Source files
------------

// File: rtl/video_timing_pkg.sv
// ---------------------------------------------------------------------------
// video_timing_pkg
// Shared definitions for the raster timing source and its consumers
// (pixel_gen). Holds the run/drain state type, the default 640x480@60
// timing constants and the raster boundaries derived from them.
// ---------------------------------------------------------------------------
package video_timing_pkg;

  // Raster FSM: IDLE holds the counters at zero; RUN and DRAIN both scan,
  // DRAIN additionally stops at the end of the current frame.
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } timing_state_e;

  // Width of the pixel and line counters.
  localparam int unsigned CNT_W = 12;

  // Default 640x480@60 horizontal timing (pixels).
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;

  // Default 640x480@60 vertical timing (lines).
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Derived default raster boundaries.
  localparam int unsigned H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned HS_END   = HS_START + DEF_H_SYNC;
  localparam int unsigned VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned VS_END   = VS_START + DEF_V_SYNC;

  // Visible extent as seen by pixel_gen.
  localparam int unsigned MAX_PIXEL = DEF_H_ACTIVE;
  localparam int unsigned MAX_LINE  = DEF_V_ACTIVE;

endpackage

// File: rtl/timing_counter.sv
// ---------------------------------------------------------------------------
// timing_counter
// Wrapping up-counter used for both raster axes. Counts 0..TERMINAL and
// wraps to 0 on the increment taken while at TERMINAL.
// Ports:
//   clk_i    clock, all logic on posedge
//   clear_i  synchronous clear to 0, dominates inc_i
//   inc_i    advance the count by one this cycle
//   count_o  current count (registered)
//   tc_o     high while count_o == TERMINAL
// ---------------------------------------------------------------------------
module timing_counter
  import video_timing_pkg::*;
#(
  parameter int unsigned      WIDTH    = CNT_W,
  parameter logic [WIDTH-1:0] TERMINAL = '1
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign tc_o    = (count_q == TERMINAL);
  assign count_o = count_q;

  // Next count: hold, step, or wrap to zero at the terminal value.
  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      count_d = tc_o ? '0 : count_q + 1'b1;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
// Raster timing source for pixel_gen / VGA DAC. Scans pixel and line
// counters, decodes blanking and sync, and starts/stops only on frame
// boundaries. Every output is registered and describes the same raster
// position in the same cycle.
// Ports:
//   rfr_clk_i      pixel clock
//   reset_i        synchronous active-high reset, dominates en_i
//   en_i           request raster output, sampled every cycle
//   pixel_cnt_o    horizontal position 0..H_TOTAL-1
//   line_cnt_o     vertical position 0..V_TOTAL-1
//   video_on_o     inside the visible area while scanning
//   h_sync_o       horizontal sync, HS_POL when asserted
//   v_sync_o       vertical sync, VS_POL when asserted
//   frame_start_o  one-cycle pulse at position (0,0)
//   line_end_o     one-cycle pulse at pixel H_TOTAL-1
//   running_o      scanning (RUN or DRAIN)
//   frame_cnt_o    completed frames, wrapping
// ---------------------------------------------------------------------------
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned FRAME_W  = 16
) (
  input  logic               rfr_clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  output logic [CNT_W-1:0]   pixel_cnt_o,
  output logic [CNT_W-1:0]   line_cnt_o,
  output logic               video_on_o,
  output logic               h_sync_o,
  output logic               v_sync_o,
  output logic               frame_start_o,
  output logic               line_end_o,
  output logic               running_o,
  output logic [FRAME_W-1:0] frame_cnt_o
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Boundaries precomputed so the datapath only compares.
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOT - 1);

  if (H_TOT > 4096 || V_TOT > 4096) begin : gen_size_check
    $error("video_timing_gen: H_TOTAL and V_TOTAL must not exceed 4096");
  end

  timing_state_e state_q, state_d;

  logic [CNT_W-1:0] hCnt, vCnt;
  logic             hTc, vTc;
  logic             scanning;
  logic             frameEnd;
  logic [CNT_W-1:0] hNext, vNext;
  logic             nextActive;

  logic               videoOn_q, videoOn_d;
  logic               hSync_q, hSync_d;
  logic               vSync_q, vSync_d;
  logic               frameStart_q, frameStart_d;
  logic               lineEnd_q, lineEnd_d;
  logic               running_q;
  logic [FRAME_W-1:0] frameCnt_q;

  assign scanning = (state_q != IDLE);
  assign frameEnd = scanning && hTc && vTc;

  timing_counter #(
    .WIDTH    (CNT_W),
    .TERMINAL (H_LAST_C)
  ) u_hCounter (
    .clk_i   (rfr_clk_i),
    .clear_i (reset_i),
    .inc_i   (scanning),
    .count_o (hCnt),
    .tc_o    (hTc)
  );

  timing_counter #(
    .WIDTH    (CNT_W),
    .TERMINAL (V_LAST_C)
  ) u_vCounter (
    .clk_i   (rfr_clk_i),
    .clear_i (reset_i),
    .inc_i   (scanning && hTc),
    .count_o (vCnt),
    .tc_o    (vTc)
  );

  // State register for the run/drain controller.
  always_ff @(posedge rfr_clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: DRAIN keeps scanning and only drops to IDLE on the last
  // pixel of a frame, so display always stops on a frame boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_i) state_d = RUN;
      RUN:     if (!en_i) state_d = DRAIN;
      DRAIN: begin
        if (en_i) begin
          state_d = RUN;
        end else if (hTc && vTc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Position the counters will hold next cycle; decoding this instead of
  // the current count keeps the registered flags aligned with the counters.
  always_comb begin
    hNext = '0;
    vNext = '0;
    if (scanning) begin
      hNext = hTc ? '0 : hCnt + 1'b1;
      vNext = vCnt;
      if (hTc) begin
        vNext = vTc ? '0 : vCnt + 1'b1;
      end
    end
  end

  // Decode of the upcoming position, masked when heading into IDLE.
  always_comb begin
    nextActive   = (state_d != IDLE);
    videoOn_d    = nextActive && (hNext < H_ACT_C) && (vNext < V_ACT_C);
    hSync_d      = (nextActive && (hNext >= HS_BEG_C) && (hNext < HS_END_C)) ? HS_POL : ~HS_POL;
    vSync_d      = (nextActive && (vNext >= VS_BEG_C) && (vNext < VS_END_C)) ? VS_POL : ~VS_POL;
    frameStart_d = nextActive && (hNext == '0) && (vNext == '0);
    lineEnd_d    = nextActive && (hNext == H_LAST_C);
  end

  // Output registers and completed-frame counter.
  always_ff @(posedge rfr_clk_i) begin
    if (reset_i) begin
      videoOn_q    <= 1'b0;
      hSync_q      <= ~HS_POL;
      vSync_q      <= ~VS_POL;
      frameStart_q <= 1'b0;
      lineEnd_q    <= 1'b0;
      running_q    <= 1'b0;
      frameCnt_q   <= '0;
    end else begin
      videoOn_q    <= videoOn_d;
      hSync_q      <= hSync_d;
      vSync_q      <= vSync_d;
      frameStart_q <= frameStart_d;
      lineEnd_q    <= lineEnd_d;
      running_q    <= nextActive;
      if (frameEnd) begin
        frameCnt_q <= frameCnt_q + 1'b1;
      end
    end
  end

  assign pixel_cnt_o   = hCnt;
  assign line_cnt_o    = vCnt;
  assign video_on_o    = videoOn_q;
  assign h_sync_o      = hSync_q;
  assign v_sync_o      = vSync_q;
  assign frame_start_o = frameStart_q;
  assign line_end_o    = lineEnd_q;
  assign running_o     = running_q;
  assign frame_cnt_o   = frameCnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
// Self-checking bench for video_timing_gen using a reduced raster
// (32x20 total, 16x12 visible) and a 4-bit frame counter so complete frames
// and frame-counter wrap stay short. Expected outputs come from a model that
// tracks a linear raster index and splits it into (x,y) arithmetically.
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

  localparam int HA  = 16;
  localparam int HFP = 4;
  localparam int HSW = 6;
  localparam int HBP = 6;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VA  = 12;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 4;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int FW  = 4;
  localparam int FRAME_PIX = HT * VT;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [11:0]   pixelCnt;
  logic [11:0]   lineCnt;
  logic          videoOn;
  logic          hSync;
  logic          vSync;
  logic          frameStart;
  logic          lineEnd;
  logic          running;
  logic [FW-1:0] frameCnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state: scanning flag, stop-pending flag, linear index.
  bit mOn    = 1'b0;
  bit mDrain = 1'b0;
  int mPos   = 0;
  int mFrames = 0;

  video_timing_gen #(
    .H_ACTIVE (HA),
    .H_FP     (HFP),
    .H_SYNC   (HSW),
    .H_BP     (HBP),
    .V_ACTIVE (VA),
    .V_FP     (VFP),
    .V_SYNC   (VSW),
    .V_BP     (VBP),
    .HS_POL   (1'b0),
    .VS_POL   (1'b0),
    .FRAME_W  (FW)
  ) dut (
    .rfr_clk_i     (clk),
    .reset_i       (reset),
    .en_i          (en),
    .pixel_cnt_o   (pixelCnt),
    .line_cnt_o    (lineCnt),
    .video_on_o    (videoOn),
    .h_sync_o      (hSync),
    .v_sync_o      (vSync),
    .frame_start_o (frameStart),
    .line_end_o    (lineEnd),
    .running_o     (running),
    .frame_cnt_o   (frameCnt)
  );

  always #5 clk = ~clk;

  // Model update for one clock edge, from the inputs seen at that edge.
  task automatic modelStep();
    bit last;
    if (reset) begin
      mOn = 1'b0; mDrain = 1'b0; mPos = 0; mFrames = 0;
    end else if (!mOn) begin
      if (en) begin
        mOn = 1'b1; mDrain = 1'b0; mPos = 0;
      end
    end else begin
      last = (mPos == FRAME_PIX - 1);
      if (last) mFrames++;
      if (last && mDrain && !en) begin
        mOn = 1'b0; mPos = 0;
      end else begin
        mPos = (mPos + 1) % FRAME_PIX;
      end
      mDrain = !en;
    end
  endtask

  // Expected output vector for the current model position.
  function automatic logic [33:0] expVec();
    int x, y;
    logic vid, hs, vs, fs, le;
    x   = mPos % HT;
    y   = mPos / HT;
    vid = mOn && x < HA && y < VA;
    hs  = !(mOn && x >= HA + HFP && x < HA + HFP + HSW);
    vs  = !(mOn && y >= VA + VFP && y < VA + VFP + VSW);
    fs  = mOn && mPos == 0;
    le  = mOn && x == HT - 1;
    return {12'(x), 12'(y), vid, hs, vs, fs, le, mOn, 4'(mFrames)};
  endfunction

  function automatic logic [33:0] obsVec();
    return {pixelCnt, lineCnt, videoOn, hSync, vSync, frameStart, lineEnd, running, frameCnt};
  endfunction

  // One clock: advance the model at the edge, then settle past it.
  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  // Tick until the outputs show (x,y); returns 0 if the bound runs out.
  task automatic runTo(input int x, input int y, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * FRAME_PIX; i++) begin
      if (pixelCnt == 12'(x) && lineCnt == 12'(y)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obsVec() !== expVec()) begin
        failures++;
        $display("[TB] FAIL reset_model: got %h expected %h", obsVec(), expVec());
      end
    end
    checks++;
    if (obsVec() !== {12'd0, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      failures++;
      $display("[TB] FAIL reset_values: got %h expected %h", obsVec(),
               {12'd0, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    end
  endtask

  task automatic test_startup();
    int firstOff = -1;
    int hsLow    = 0;
    int hsFirst  = -1;
    reset = 1'b0;
    en    = 1'b1;
    tick();
    checks++;
    if ({pixelCnt, lineCnt, videoOn, frameStart, running} !== {24'd0, 3'b111}) begin
      failures++;
      $display("[TB] FAIL start_first: got %h expected %h",
               {pixelCnt, lineCnt, videoOn, frameStart, running}, {24'd0, 3'b111});
    end
    for (int i = 1; i <= HT; i++) begin
      tick();
      checks++;
      if (obsVec() !== expVec()) begin
        failures++;
        $display("[TB] FAIL start_model: got %h expected %h", obsVec(), expVec());
      end
      if (lineCnt == 12'd0) begin
        if (!videoOn && firstOff < 0) firstOff = int'(pixelCnt);
        if (!hSync) begin
          hsLow++;
          if (hsFirst < 0) hsFirst = int'(pixelCnt);
        end
      end
    end
    checks++;
    if (firstOff != HA) begin
      failures++;
      $display("[TB] FAIL video_off_pixel: got %0d expected %0d", firstOff, HA);
    end
    checks++;
    if (hsLow != HSW || hsFirst != HA + HFP) begin
      failures++;
      $display("[TB] FAIL hsync_window: got width %0d start %0d expected width %0d start %0d",
               hsLow, hsFirst, HSW, HA + HFP);
    end
    checks++;
    if (pixelCnt !== 12'd0 || lineCnt !== 12'd1) begin
      failures++;
      $display("[TB] FAIL line_advance: got (%0d,%0d) expected (0,1)", pixelCnt, lineCnt);
    end
  endtask

  task automatic test_frame();
    int   sinceFs = HT;
    int   vsLines = 0;
    int   vsFirst = -1;
    int   vsLast  = -1;
    bit   gotFs   = 1'b0;
    logic prevVs;
    prevVs = vSync;
    for (int i = 0; i < 2 * FRAME_PIX; i++) begin
      tick();
      sinceFs++;
      checks++;
      if (obsVec() !== expVec()) begin
        failures++;
        $display("[TB] FAIL frame_model: got %h expected %h", obsVec(), expVec());
      end
      if (vSync !== prevVs && pixelCnt != 12'd0) begin
        failures++;
        $display("[TB] FAIL vsync_edge: vsync moved at pixel %0d expected pixel 0", pixelCnt);
      end
      prevVs = vSync;
      if (pixelCnt == 12'd0 && !vSync) begin
        vsLines++;
        if (vsFirst < 0) vsFirst = int'(lineCnt);
        vsLast = int'(lineCnt);
      end
      if (frameStart) begin
        gotFs = 1'b1;
        break;
      end
    end
    checks++;
    if (!gotFs || sinceFs != FRAME_PIX) begin
      failures++;
      $display("[TB] FAIL frame_period: got %0d cycles expected %0d", sinceFs, FRAME_PIX);
    end
    checks++;
    if (vsLines != VSW || vsFirst != VA + VFP || vsLast != VA + VFP + VSW - 1) begin
      failures++;
      $display("[TB] FAIL vsync_lines: got %0d lines %0d..%0d expected %0d lines %0d..%0d",
               vsLines, vsFirst, vsLast, VSW, VA + VFP, VA + VFP + VSW - 1);
    end
    checks++;
    if (frameCnt !== 4'd1) begin
      failures++;
      $display("[TB] FAIL frame_cnt_first: got %0d expected 1", frameCnt);
    end
  endtask

  task automatic test_drain();
    bit           ok;
    int           lastX = -1;
    int           lastY = -1;
    logic [FW-1:0] fc0;
    int           startIdx;
    runTo(5, 7, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL drain_reach: got (%0d,%0d) expected (5,7)", pixelCnt, lineCnt);
    end
    fc0 = frameCnt;
    en  = 1'b0;
    ok  = 1'b0;
    for (int i = 0; i < 2 * FRAME_PIX; i++) begin
      tick();
      checks++;
      if (obsVec() !== expVec()) begin
        failures++;
        $display("[TB] FAIL drain_model: got %h expected %h", obsVec(), expVec());
      end
      if (running) begin
        lastX = int'(pixelCnt);
        lastY = int'(lineCnt);
      end else begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || lastX != HT - 1 || lastY != VT - 1) begin
      failures++;
      $display("[TB] FAIL drain_last: got (%0d,%0d) expected (%0d,%0d)", lastX, lastY, HT - 1, VT - 1);
    end
    checks++;
    if (frameCnt !== FW'(fc0 + 1'b1) || pixelCnt !== 12'd0 || videoOn !== 1'b0 || hSync !== 1'b1) begin
      failures++;
      $display("[TB] FAIL drain_idle: got fc %0d pix %0d vid %b hs %b expected fc %0d pix 0 vid 0 hs 1",
               frameCnt, pixelCnt, videoOn, hSync, FW'(fc0 + 1'b1));
    end
    // Resume, then dip en for 50 cycles mid-frame.
    en = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) tick();
    startIdx = int'(lineCnt) * HT + int'(pixelCnt);
    en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) en = 1'b1;
      tick();
      checks++;
      if (obsVec() !== expVec() || running !== 1'b1) begin
        failures++;
        $display("[TB] FAIL en_dip_model: got %h expected %h", obsVec(), expVec());
      end
    end
    checks++;
    if (int'(lineCnt) * HT + int'(pixelCnt) != startIdx + 100) begin
      failures++;
      $display("[TB] FAIL en_dip_position: got %0d expected %0d",
               int'(lineCnt) * HT + int'(pixelCnt), startIdx + 100);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    runTo(9, 10, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL rmid_reach: got (%0d,%0d) expected (9,10)", pixelCnt, lineCnt);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (obsVec() !== {12'd0, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      failures++;
      $display("[TB] FAIL rmid_values: got %h expected %h", obsVec(),
               {12'd0, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    end
    reset = 1'b0;
    en    = 1'b1;
    tick();
    checks++;
    if ({pixelCnt, lineCnt, frameStart, running, frameCnt} !== {24'd0, 2'b11, 4'd0}) begin
      failures++;
      $display("[TB] FAIL rmid_restart: got %h expected %h",
               {pixelCnt, lineCnt, frameStart, running, frameCnt}, {24'd0, 2'b11, 4'd0});
    end
  endtask

  task automatic test_frame_wrap();
    for (int f = 1; f <= (1 << FW); f++) begin
      for (int i = 0; i < FRAME_PIX; i++) begin
        tick();
        if (obsVec() !== expVec()) begin
          checks++;
          failures++;
          $display("[TB] FAIL wrap_model: got %h expected %h", obsVec(), expVec());
        end
      end
      checks++;
      if (frameCnt !== FW'(f) || frameStart !== 1'b1) begin
        failures++;
        $display("[TB] FAIL wrap_count: got %0d fs %b expected %0d fs 1", frameCnt, frameStart, FW'(f));
      end
    end
  endtask

  task automatic test_random();
    logic expVid, expHs, expVs;
    for (int i = 0; i < 6000; i++) begin
      reset = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 299) == 0) en = ~en;
      tick();
      checks++;
      if (obsVec() !== expVec()) begin
        failures++;
        $display("[TB] FAIL rand_model: got %h expected %h", obsVec(), expVec());
      end
      expVid = running && pixelCnt < 12'(HA) && lineCnt < 12'(VA);
      expHs  = !(running && pixelCnt >= 12'(HA + HFP) && pixelCnt < 12'(HA + HFP + HSW));
      expVs  = !(running && lineCnt >= 12'(VA + VFP) && lineCnt < 12'(VA + VFP + VSW));
      checks++;
      if ({videoOn, hSync, vSync} !== {expVid, expHs, expVs}) begin
        failures++;
        $display("[TB] FAIL rand_decode: got %b%b%b expected %b%b%b at (%0d,%0d)",
                 videoOn, hSync, vSync, expVid, expHs, expVs, pixelCnt, lineCnt);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    test_reset();
    test_startup();
    test_frame();
    test_drain();
    test_reset_mid();
    test_frame_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
